// File: rtl/mips_cpu_pkg.sv
// Shared types for the multi-cycle MIPS core: control FSM states, the memory
// sequencer states, access sizes and byte-lane patterns.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } mem_kind_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Bytes are always aligned; an undefined size code is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Little-endian lane steering: store replication and byte enables on the way
// out, lane selection and sign/zero extension on the way back.
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] readdata_i,
  input  logic        sign_ext_i,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byteenable_o = BE_WORD;
    writedata_o  = wdata_i;
    load_data_o  = readdata_i;
    misaligned_o = is_misaligned(size_i, addr_lo_i);
    byte_s       = 8'h00;
    half_s       = 16'h0000;
    case (size_i)
      SZ_BYTE: begin
        byteenable_o = BE_BYTE0 << addr_lo_i;
        writedata_o  = {4{wdata_i[7:0]}};
        case (addr_lo_i)
          2'd0:    byte_s = readdata_i[7:0];
          2'd1:    byte_s = readdata_i[15:8];
          2'd2:    byte_s = readdata_i[23:16];
          default: byte_s = readdata_i[31:24];
        endcase
        load_data_o = {{24{sign_ext_i & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        byteenable_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        writedata_o  = {2{wdata_i[15:0]}};
        if (addr_lo_i[1]) begin
          half_s = readdata_i[31:16];
        end else begin
          half_s = readdata_i[15:0];
        end
        load_data_o = {{16{sign_ext_i & half_s[15]}}, half_s};
      end
      default: begin
        byteenable_o = BE_WORD;
        writedata_o  = wdata_i;
        load_data_o  = readdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_ctrl.sv
// Memory-access sequencer: arbitrates fetch and data requests onto a single
// Avalon-style port, holds strobes through waitrequest and returns results.
module mips_cpu_mem_ctrl
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_req,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] instr,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  mem_state_t  state_q, state_d;
  mem_kind_t   kind_q, kind_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        sext_q, sext_d;
  logic        read_q, read_d, write_q, write_d;
  logic        done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [31:0] instr_q, instr_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;

  logic        accept_s;
  logic [1:0]  al_size_s, al_addr_s;
  logic        al_sext_s;
  logic [3:0]  al_be_s;
  logic [31:0] al_wdata_s, al_load_s;
  logic        al_mis_s;

  assign accept_s = (state_q == IDLE) && (data_req || ifetch_req);

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  always_comb begin
    if (state_q == IDLE) begin
      al_size_s = data_req ? size : SZ_WORD;
      al_addr_s = addr[1:0];
      al_sext_s = sign_ext;
    end else begin
      al_size_s = size_q;
      al_addr_s = addr_lo_q;
      al_sext_s = sext_q;
    end
  end

  mips_cpu_lane_align u_lane_align (
    .size_i       (al_size_s),
    .addr_lo_i    (al_addr_s),
    .wdata_i      (wdata),
    .readdata_i   (readdata),
    .sign_ext_i   (al_sext_s),
    .byteenable_o (al_be_s),
    .writedata_o  (al_wdata_s),
    .load_data_o  (al_load_s),
    .misaligned_o (al_mis_s)
  );

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kind_q      <= K_FETCH;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      sext_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      address_q   <= 32'h0000_0000;
      writedata_q <= 32'h0000_0000;
      be_q        <= 4'b0000;
      instr_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      sext_q      <= sext_d;
      read_q      <= read_d;
      write_q     <= write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state: a misaligned request skips BUS and goes straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = al_mis_s ? RESP : BUS;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d = RESP;
        end else begin
          state_d = BUS;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-value logic for every registered output.
  always_comb begin
    kind_d      = kind_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    sext_d      = sext_q;
    read_d      = read_q;
    write_d     = write_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    be_d        = be_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (accept_s && al_mis_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          kind_d      = data_req ? (data_we ? K_STORE : K_LOAD) : K_FETCH;
          size_d      = al_size_s;
          addr_lo_d   = addr[1:0];
          sext_d      = sign_ext;
          address_d   = {addr[31:2], 2'b00};
          be_d        = al_be_s;
          writedata_d = al_wdata_s;
          read_d      = !(data_req && data_we);
          write_d     = data_req && data_we;
        end else begin
          err_d = 1'b0;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          done_d  = 1'b1;
          case (kind_q)
            K_FETCH: instr_d = readdata;
            K_LOAD:  rdata_d = al_load_s;
            default: rdata_d = rdata_q;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      RESP:    done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign instr      = instr_q;
  assign rdata      = rdata_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = be_q;

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Self-checking bench for mips_cpu_mem_ctrl: directed scenarios plus a
// randomized sweep checked against an arithmetic reference model.
module tb_mips_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, ifetch_req, data_req, data_we, sign_ext, waitrequest;
  logic [1:0]  size;
  logic [31:0] addr, wdata, readdata;
  logic        done, err, busy, read, write;
  logic [31:0] instr, rdata, address, writedata;
  logic [3:0]  byteenable;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_instr = 32'h0;
  logic [31:0] model_rdata = 32'h0;

  int          o_rd, o_wr, o_done, o_err, o_done_cnt, o_err_cnt, o_both, o_busy_after;
  logic [31:0] o_addr, o_wd, o_rdata, o_instr;
  logic [3:0]  o_be;

  mips_cpu_mem_ctrl dut (
    .clk(clk), .reset(reset), .ifetch_req(ifetch_req), .data_req(data_req),
    .data_we(data_we), .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .done(done), .err(err), .busy(busy), .instr(instr), .rdata(rdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
    if (sz == 2'b00) return 4'b0001 << lo;
    else if (sz == 2'b01) return 4'h3 << (2 * lo[1]);
    else return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
    else if (sz == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
    else return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] lo,
                                         input logic sx, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // kind: 0 fetch, 1 load, 2 store
  task automatic set_req(input int kind, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
    ifetch_req = (kind == 0);
    data_req   = (kind != 0);
    data_we    = (kind == 2);
    size = sz; sign_ext = sx; addr = a; wdata = wd;
  endtask

  // Runs one access from the request cycle N, recording what the bus did.
  task automatic run_txn(input int waits, input logic [31:0] word, input bit keep_fetch);
    int stop;
    stop = -1;
    o_rd = 0; o_wr = 0; o_done = -1; o_err = -1; o_done_cnt = 0; o_err_cnt = 0;
    o_both = 0; o_busy_after = -1;
    o_addr = 32'h0; o_wd = 32'h0; o_be = 4'h0; o_rdata = 32'h0; o_instr = 32'h0;
    readdata = word;
    waitrequest = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        data_req = 1'b0;
        if (!keep_fetch) ifetch_req = 1'b0;
      end
      waitrequest = (cyc <= waits);
      if ((read || write) && o_rd == 0 && o_wr == 0) begin
        o_addr = address; o_be = byteenable; o_wd = writedata;
      end
      if (read) o_rd++;
      if (write) o_wr++;
      if (read && write) o_both = 1;
      if (done) begin
        o_done_cnt++;
        if (o_done < 0) begin o_done = cyc; o_rdata = rdata; o_instr = instr; end
      end
      if (err) begin
        o_err_cnt++;
        if (o_err < 0) o_err = cyc;
      end
      if (cyc == stop) begin
        o_busy_after = busy;
        break;
      end
      if ((done || err) && stop < 0) stop = cyc + 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(0, 2'b10, 1'b0, 32'h0, 32'h0);
    ifetch_req = 1'b0; readdata = 32'h0; waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({read, write, done, err, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {read, write, done, err, busy});
    end
    n_checks++;
    if ({address, writedata, byteenable, instr, rdata} !== 132'h0) begin
      n_fail++; $display("FAIL reset_data addr=%h wd=%h be=%b instr=%h rdata=%h exp all 0",
                         address, writedata, byteenable, instr, rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    set_req(0, 2'b10, 1'b0, 32'hBFC0_0000, 32'h0);
    run_txn(0, 32'h8C82_0004, 1'b0);
    model_instr = 32'h8C82_0004;
    n_checks++;
    if (o_rd !== 1 || o_wr !== 0) begin
      n_fail++; $display("FAIL fetch_strobes rd=%0d wr=%0d exp 1/0", o_rd, o_wr);
    end
    n_checks++;
    if (o_addr !== 32'hBFC0_0000 || o_be !== 4'hF) begin
      n_fail++; $display("FAIL fetch_bus addr=%h be=%b exp bfc00000/1111", o_addr, o_be);
    end
    n_checks++;
    if (o_done !== 2 || o_instr !== model_instr) begin
      n_fail++; $display("FAIL fetch_result done_lat=%0d instr=%h exp 2/%h", o_done, o_instr, model_instr);
    end
    n_checks++;
    if (o_busy_after !== 0) begin
      n_fail++; $display("FAIL fetch_idle busy=%0d exp 0", o_busy_after);
    end
  endtask

  task automatic test_load_byte_stall;
    set_req(1, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    run_txn(3, 32'h8011_2233, 1'b0);
    n_checks++;
    if (o_rd !== 4 || o_be !== 4'b1000 || o_addr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL lb_bus rd=%0d be=%b addr=%h exp 4/1000/00001000", o_rd, o_be, o_addr);
    end
    n_checks++;
    if (o_done !== 5 || o_rdata !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_sext done_lat=%0d rdata=%h exp 5/ffffff80", o_done, o_rdata);
    end
    set_req(1, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    run_txn(3, 32'h8011_2233, 1'b0);
    model_rdata = 32'h0000_0080;
    n_checks++;
    if (o_rdata !== model_rdata || o_instr !== model_instr) begin
      n_fail++; $display("FAIL lb_zext rdata=%h instr=%h exp %h/%h", o_rdata, o_instr, model_rdata, model_instr);
    end
  endtask

  task automatic test_store_half;
    set_req(2, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    run_txn(0, 32'h0, 1'b0);
    n_checks++;
    if (o_wr !== 1 || o_rd !== 0 || o_addr !== 32'h0000_2000) begin
      n_fail++; $display("FAIL sh_strobe wr=%0d rd=%0d addr=%h exp 1/0/00002000", o_wr, o_rd, o_addr);
    end
    n_checks++;
    if (o_be !== 4'b1100 || o_wd !== 32'hBEEF_BEEF || o_done !== 2) begin
      n_fail++; $display("FAIL sh_lanes be=%b wd=%h done_lat=%0d exp 1100/beefbeef/2", o_be, o_wd, o_done);
    end
    n_checks++;
    if (o_rdata !== model_rdata) begin
      n_fail++; $display("FAIL sh_rdata_hold rdata=%h exp %h", o_rdata, model_rdata);
    end
  endtask

  task automatic test_simultaneous;
    set_req(1, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    ifetch_req = 1'b1;
    run_txn(0, 32'h1234_5678, 1'b1);
    model_rdata = 32'h1234_5678;
    n_checks++;
    if (o_addr !== 32'h0000_0040 || o_rd !== 1 || o_rdata !== model_rdata) begin
      n_fail++; $display("FAIL simul_data_first addr=%h rd=%0d rdata=%h exp 00000040/1/%h",
                         o_addr, o_rd, o_rdata, model_rdata);
    end
    addr = 32'hBFC0_0010;
    readdata = 32'h2408_0001;
    @(posedge clk); #1;
    ifetch_req = 1'b0;
    n_checks++;
    if (read !== 1'b1 || address !== 32'hBFC0_0010) begin
      n_fail++; $display("FAIL simul_fetch_next read=%b addr=%h exp 1/bfc00010", read, address);
    end
    @(posedge clk); #1;
    model_instr = 32'h2408_0001;
    n_checks++;
    if (done !== 1'b1 || instr !== model_instr || read !== 1'b0) begin
      n_fail++; $display("FAIL simul_fetch_done done=%b instr=%h read=%b exp 1/%h/0", done, instr, read, model_instr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned;
    set_req(1, 2'b10, 1'b0, 32'h0000_0041, 32'h0);
    run_txn(0, 32'hDEAD_BEEF, 1'b0);
    n_checks++;
    if (o_rd !== 0 || o_wr !== 0 || o_done_cnt !== 0) begin
      n_fail++; $display("FAIL mis_nobus rd=%0d wr=%0d done_cnt=%0d exp 0/0/0", o_rd, o_wr, o_done_cnt);
    end
    n_checks++;
    if (o_err !== 1 || o_err_cnt !== 1 || o_busy_after !== 0) begin
      n_fail++; $display("FAIL mis_err err_lat=%0d err_cnt=%0d busy=%0d exp 1/1/0", o_err, o_err_cnt, o_busy_after);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    set_req(1, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
    readdata = 32'hCAFE_F00D;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    data_req = 1'b0;
    n_checks++;
    if (read !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre read=%b exp 1", read);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_instr = 32'h0; model_rdata = 32'h0;
    n_checks++;
    if ({read, write, done, err, busy} !== 5'b0 ||
        {address, writedata, byteenable, instr, rdata} !== 132'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs rd=%b wr=%b done=%b err=%b busy=%b addr=%h instr=%h rdata=%h exp all 0",
                         read, write, done, err, busy, address, instr, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || read || write) pulses++;
    end
    waitrequest = 1'b0;
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL rst_mid_abandon activity_cycles=%0d exp 0", pulses);
    end
    set_req(0, 2'b10, 1'b0, 32'hBFC0_0004, 32'h0);
    run_txn(0, 32'h0000_000C, 1'b0);
    model_instr = 32'h0000_000C;
    n_checks++;
    if (o_done !== 2 || o_instr !== model_instr) begin
      n_fail++; $display("FAIL rst_mid_refetch done_lat=%0d instr=%h exp 2/%h", o_done, o_instr, model_instr);
    end
  endtask

  task automatic test_back_to_back;
    set_req(0, 2'b10, 1'b0, 32'h0040_0000, 32'h0);
    run_txn(1, 32'hAAAA_0001, 1'b0);
    set_req(0, 2'b10, 1'b0, 32'h0040_0004, 32'h0);
    run_txn(0, 32'hAAAA_0002, 1'b0);
    model_instr = 32'hAAAA_0002;
    n_checks++;
    if (o_done !== 2 || o_instr !== model_instr || o_addr !== 32'h0040_0004) begin
      n_fail++; $display("FAIL b2b_second done_lat=%0d instr=%h addr=%h exp 2/%h/00400004",
                         o_done, o_instr, o_addr, model_instr);
    end
  endtask

  task automatic test_random;
    int kind, waits, strobes, other;
    logic [1:0]  sz, esz;
    logic        sx, mis;
    logic [31:0] a, wd, word;
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 2);
      sz    = 2'($urandom_range(0, 2));
      sx    = 1'($urandom_range(0, 1));
      a     = $urandom;
      wd    = $urandom;
      word  = $urandom;
      waits = $urandom_range(0, 3);
      esz   = (kind == 0) ? 2'b10 : sz;
      mis   = (esz == 2'b01 && a[0]) || (esz == 2'b10 && a[1:0] != 2'b00);
      set_req(kind, sz, sx, a, wd);
      run_txn(waits, word, 1'b0);
      if (mis) begin
        n_checks++;
        if (o_err !== 1 || o_rd !== 0 || o_wr !== 0 || o_done_cnt !== 0) begin
          n_fail++; $display("FAIL rnd_mis it=%0d err_lat=%0d rd=%0d wr=%0d done_cnt=%0d exp 1/0/0/0",
                             it, o_err, o_rd, o_wr, o_done_cnt);
        end
      end else begin
        if (kind == 0) model_instr = word;
        else if (kind == 1) model_rdata = m_load(esz, a[1:0], sx, word);
        strobes = (kind == 2) ? o_wr : o_rd;
        other   = (kind == 2) ? o_rd : o_wr;
        n_checks++;
        if (o_done !== waits + 2 || strobes !== waits + 1 || other !== 0 || o_both !== 0 || o_err_cnt !== 0) begin
          n_fail++; $display("FAIL rnd_timing it=%0d done_lat=%0d strobes=%0d other=%0d exp %0d/%0d/0",
                             it, o_done, strobes, other, waits + 2, waits + 1);
        end
        n_checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(esz, a[1:0]) ||
            (kind == 2 && o_wd !== m_wd(esz, wd))) begin
          n_fail++; $display("FAIL rnd_bus it=%0d addr=%h be=%b wd=%h exp %h/%b/%h",
                             it, o_addr, o_be, o_wd, {a[31:2], 2'b00}, m_be(esz, a[1:0]), m_wd(esz, wd));
        end
        n_checks++;
        if (o_instr !== model_instr || o_rdata !== model_rdata || o_busy_after !== 0) begin
          n_fail++; $display("FAIL rnd_result it=%0d instr=%h rdata=%h busy=%0d exp %h/%h/0",
                             it, o_instr, o_rdata, o_busy_after, model_instr, model_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load_byte_stall;
    test_store_half;
    test_simultaneous;
    test_misaligned;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_ctrl.md
# mips_cpu_mem_ctrl

Memory-access sequencer between the multi-cycle control FSM of `mips_cpu_bus` and its Avalon-style memory port. It arbitrates instruction-fetch and data (load/store) requests onto the single bus, holds the strobes through `waitrequest` stalls, generates byte lanes for byte/half/word accesses, and returns the fetched instruction or the sign/zero-extended load data. The CPU FSM stalls its FETCH_INSTR and MEMORY_ACCESS states on `done`.

## Interface
- No parameters; data and address width are fixed at 32.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ifetch_req`  in  1  instruction-fetch request; `addr` is the PC.
- `data_req`  in  1  load/store request.
- `data_we`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10.
- `sign_ext`  in  1  load extension: 1 = sign, 0 = zero.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-justified.
- `done`  out  1  one-cycle pulse when the request completes.
- `err`  out  1  one-cycle pulse when a misaligned request is rejected.
- `busy`  out  1  high in the BUS and RESP states.
- `instr`  out  32  last fetched instruction word; held until the next fetch.
- `rdata`  out  32  last load result, already extended; held.
- `address`  out  32  bus word address, `{addr[31:2],2'b00}`.
- `read`, `write`  out  1  bus read and write strobes.
- `writedata`  out  32  bus write data.
- `byteenable`  out  4  bus byte lanes.
- `readdata`  in  32  bus read data.
- `waitrequest`  in  1  bus stall.

## Operation
- **States.** IDLE, BUS, RESP, held in the `mem_state_t` enum.
- **IDLE.**
  - Requests are sampled only in IDLE.
  - If `data_req` and `ifetch_req` are both high, the data request wins.
  - An accepted request is latched into `address`, `byteenable`, `writedata` and the kind (fetch/load/store, size, extension). The controller then moves to BUS with `read` (fetch or load) or `write` (store) registered high.
- **Misalignment.** Defined as SZ_HALF with `addr[0]=1`, or SZ_WORD with `addr[1:0]≠0`; fetches are always SZ_WORD.
  - A misaligned request makes no bus access.
  - `err` pulses the next cycle, then the state goes to RESP.
  - `done` stays 0.
- **BUS.** All bus outputs are held stable while `waitrequest=1`. At the first rising edge with `waitrequest=0`:
  - the transfer completes and `read`/`write` drop to 0;
  - on a read, `readdata` is captured into `instr` (fetch) or into `rdata`;
  - the state moves to RESP with `done=1`.
- **RESP.** Lasts one cycle and ignores all requests. The requester deasserts its request during this cycle. Next state is IDLE.
- **Store lanes (little-endian).**
  - Byte: `byteenable = 4'b0001 << addr[1:0]`, `writedata = {4{wdata[7:0]}}`.
  - Half: `byteenable = addr[1] ? 1100 : 0011`, `writedata = {2{wdata[15:0]}}`.
  - Word: `byteenable = 1111`, `writedata = wdata`.
- **Reads.** `byteenable` is the same lane pattern as for stores.
  - The load selects its byte or half lane from `readdata` and extends it per `sign_ext`.
  - Fetches use 1111 and capture `readdata` unmodified.
- **Reset.** All outputs go to 0: `read`, `write`, `address`, `writedata`, `byteenable`, `done`, `err`, `busy`, `instr`, `rdata`. The state goes to IDLE.
  - A reset asserted during BUS drops the strobes at that edge, abandoning the transfer.
  - No `done` is issued for an abandoned transfer.

## Timing
- **Zero-wait latency.** With the request high in cycle N:
  - strobes are high in N+1;
  - `done` is high in N+2 (RESP);
  - the controller is back in IDLE in N+3, where the next request may be accepted.
- **With stalls.** Each `waitrequest=1` edge in BUS adds one cycle. The strobes are high for exactly (wait cycles + 1) cycles.
- **Result timing.** `instr` and `rdata` are valid in the same cycle as `done` and hold until overwritten.
- **Misaligned requests.** The request in cycle N gives `err` in N+1 and IDLE in N+2.
- **Strobe exclusivity.** `read` and `write` are never high together.
- **`busy`.** Registered and equal to (state ≠ IDLE).

## Structure
- **Package `mips_cpu_pkg`.** Holds `mem_state_t` {IDLE, BUS, RESP}, `mem_size_t` {SZ_BYTE, SZ_HALF, SZ_WORD} and the lane constants. It is shared with the CPU control FSM, whose `state_t` (FETCH_INSTR..WRITE_BACK) moves into the same package.
- **Sub-module `mips_cpu_lane_align`.** Purely combinational. It maps (`size`, `addr[1:0]`, `wdata`, `readdata`, `sign_ext`) to (`byteenable`, `writedata`, extended load data, `misaligned`). The sequencer FSM and registers stay in `mips_cpu_mem_ctrl`.

## Test plan
- **Fetch, no wait.** `ifetch_req`, `addr=0xBFC00000`, memory word 0x8C820004 → `read` high for 1 cycle, `address=0xBFC00000`, `byteenable=1111`, `done` 2 cycles after the request, `instr=0x8C820004`.
- **Load byte with stall.** LB at `addr=0x1003` with sign extension, `waitrequest` high for 3 cycles, word 0x80112233 → `read` high for 4 cycles, `byteenable=1000`, `rdata=0xFFFFFF80`. The same access with zero extension → `rdata=0x00000080`.
- **Store half.** SH at `addr=0x2002`, `wdata=0x0000BEEF` → `write=1`, `address=0x2000`, `byteenable=1100`, `writedata=0xBEEFBEEF`, `done` 1 cycle later.
- **Simultaneous requests.** `ifetch_req` and `data_req` (LW at 0x40) high together → the data access is serviced first (`address=0x40`). The held fetch is accepted in the IDLE cycle after RESP.
- **Misaligned word.** LW at `addr=0x41` → no `read`, `err` pulses for 1 cycle, `done` stays 0, IDLE 2 cycles later.
- **Reset mid-transfer.** `reset` during BUS with `waitrequest=1` → `read=0` and all outputs 0 at that edge, no `done`. A fresh fetch after reset completes normally.
